// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the D-stage hazard scoreboard.
// Entries are stored at a fixed maximum width so the struct can live in a package.
package hazard_scoreboard_pkg;

  localparam int RA_W_DEF = 5;
  localparam int T_W_DEF  = 2;
  localparam int RA_W_MAX = 8;
  localparam int T_W_MAX  = 4;

  localparam int FWD_RF = 0;
  localparam int FWD_E  = 1;
  localparam int FWD_M  = 2;
  localparam int FWD_W  = 3;

  typedef struct packed {
    logic                valid;
    logic [RA_W_MAX-1:0] wa;
    logic [T_W_MAX-1:0]  tnew;
  } sb_entry_t;

  function automatic logic [T_W_MAX-1:0] tnew_dec(input logic [T_W_MAX-1:0] t);
    return (t == '0) ? '0 : t - T_W_MAX'(1);
  endfunction

  function automatic logic src_match(input sb_entry_t e, input logic use_f,
                                     input logic [RA_W_MAX-1:0] src);
    return use_f && e.valid && (e.wa == src) && (src != '0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Multiply/divide occupancy timer: loads when the mult/div leaves E, then counts down.
module md_busy_counter #(
  parameter int MD_LAT = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic busy
);

  localparam int CNT_W = $clog2(MD_LAT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Loading only from idle keeps a running count from ever being restarted.
  always_comb begin
    cnt_d = cnt_q;
    if (load && (cnt_q == '0)) begin
      cnt_d = CNT_W'(MD_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: tracks in-flight writers, raises stall and picks forwarding sources.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int RA_W   = RA_W_DEF,
  parameter int T_W    = T_W_DEF,
  parameter int MD_LAT = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        d_valid,
  input  logic [RA_W-1:0]             d_rs,
  input  logic [RA_W-1:0]             d_rt,
  input  logic                        d_use_rs,
  input  logic                        d_use_rt,
  input  logic [T_W-1:0]              d_tuse_rs,
  input  logic [T_W-1:0]              d_tuse_rt,
  input  logic                        d_wr_en,
  input  logic [RA_W-1:0]             d_wa,
  input  logic [T_W-1:0]              d_tnew,
  input  logic                        d_md_start,
  input  logic                        d_md_use,
  output logic                        stall,
  output logic [$clog2(STAGES+1)-1:0] fwd_rs_sel,
  output logic [$clog2(STAGES+1)-1:0] fwd_rt_sel,
  output logic                        md_busy
);

  localparam int SEL_W = $clog2(STAGES + 1);

  sb_entry_t ent_q [1:STAGES];
  sb_entry_t ent_d [1:STAGES];
  logic      md_e_q, md_e_d;
  logic      data_haz;
  logic      md_haz;

  logic [RA_W_MAX-1:0] rs_x, rt_x;
  logic [T_W_MAX-1:0]  tuse_rs_x, tuse_rt_x;

  assign rs_x      = RA_W_MAX'(d_rs);
  assign rt_x      = RA_W_MAX'(d_rt);
  assign tuse_rs_x = T_W_MAX'(d_tuse_rs);
  assign tuse_rt_x = T_W_MAX'(d_tuse_rt);

  // Walk oldest to youngest so the youngest ready producer is the last one written.
  always_comb begin
    data_haz   = 1'b0;
    fwd_rs_sel = SEL_W'(FWD_RF);
    fwd_rt_sel = SEL_W'(FWD_RF);
    for (int k = STAGES; k >= 1; k--) begin
      if (src_match(ent_q[k], d_use_rs, rs_x)) begin
        if (ent_q[k].tnew > tuse_rs_x) data_haz = 1'b1;
        if (ent_q[k].tnew == '0) fwd_rs_sel = SEL_W'(k);
      end
      if (src_match(ent_q[k], d_use_rt, rt_x)) begin
        if (ent_q[k].tnew > tuse_rt_x) data_haz = 1'b1;
        if (ent_q[k].tnew == '0) fwd_rt_sel = SEL_W'(k);
      end
    end
  end

  assign md_haz = (d_md_start | d_md_use) & (md_busy | md_e_q);
  assign stall  = d_valid & (data_haz | md_haz);

  always_comb begin
    ent_d[1].valid = d_valid & d_wr_en & (d_wa != '0) & ~stall;
    ent_d[1].wa    = RA_W_MAX'(d_wa);
    ent_d[1].tnew  = T_W_MAX'(d_tnew);
    for (int k = 2; k <= STAGES; k++) begin
      ent_d[k]      = ent_q[k-1];
      ent_d[k].tnew = tnew_dec(ent_q[k-1].tnew);
    end
    md_e_d = d_valid & d_md_start & ~stall;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= STAGES; k++) ent_q[k] <= '0;
      md_e_q <= 1'b0;
    end else begin
      ent_q  <= ent_d;
      md_e_q <= md_e_d;
    end
  end

  md_busy_counter #(.MD_LAT(MD_LAT)) u_md_busy_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (md_e_q),
    .busy    (md_busy)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard: one pipeline cycle per table row.
module tb_hazard_scoreboard;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic       urs;
    logic [1:0] trs;
    logic [4:0] rt;
    logic       urt;
    logic [1:0] trt;
    logic       we;
    logic [4:0] wa;
    logic [1:0] tnew;
    logic       ms;
    logic       mu;
    logic       e_stall;
    logic [1:0] e_frs;
    logic [1:0] e_frt;
    logic       e_busy;
    logic       chk_fwd;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wa;
  logic       d_use_rs, d_use_rt, d_wr_en, d_md_start, d_md_use;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t hs[$];

  hazard_scoreboard #(.STAGES(3), .RA_W(5), .T_W(2), .MD_LAT(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_use_rs   (d_use_rs),
    .d_use_rt   (d_use_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_wr_en    (d_wr_en),
    .d_wa       (d_wa),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int v, int rs, int urs, int trs, int rt, int urt, int trt,
                              int we, int wa, int tnew, int ms, int mu,
                              int es, int efrs, int efrt, int eb, int cf);
    vec_t x;
    x.v = 1'(v);     x.rs = 5'(rs);   x.urs = 1'(urs); x.trs = 2'(trs);
    x.rt = 5'(rt);   x.urt = 1'(urt); x.trt = 2'(trt);
    x.we = 1'(we);   x.wa = 5'(wa);   x.tnew = 2'(tnew);
    x.ms = 1'(ms);   x.mu = 1'(mu);
    x.e_stall = 1'(es); x.e_frs = 2'(efrs); x.e_frt = 2'(efrt); x.e_busy = 1'(eb);
    x.chk_fwd = 1'(cf);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    d_valid = x.v;   d_rs = x.rs;   d_use_rs = x.urs; d_tuse_rs = x.trs;
    d_rt = x.rt;     d_use_rt = x.urt; d_tuse_rt = x.trt;
    d_wr_en = x.we;  d_wa = x.wa;   d_tnew = x.tnew;
    d_md_start = x.ms; d_md_use = x.mu;
  endtask

  task automatic check_out(input vec_t x, input string nm);
    chk({nm, ".stall"}, 8'(stall), 8'(x.e_stall));
    chk({nm, ".md_busy"}, 8'(md_busy), 8'(x.e_busy));
    if (x.chk_fwd) begin
      chk({nm, ".fwd_rs"}, 8'(fwd_rs_sel), 8'(x.e_frs));
      chk({nm, ".fwd_rt"}, 8'(fwd_rt_sel), 8'(x.e_frt));
    end
  endtask

  task automatic apply(input vec_t x, input string nm);
    @(negedge clk);
    drive(x);
    #1;
    check_out(x, nm);
  endtask

  initial begin
    // Cycle-by-cycle program; a stalled instruction is repeated in the next row.
    tbl.push_back(mk(1, 29,1,1,  0,0,0, 1,8,2,  0,0, 0,0,0,0,1)); // lw $8
    tbl.push_back(mk(1,  8,1,1, 11,1,1, 1,10,1, 0,0, 1,0,0,0,1)); // addu stalls
    tbl.push_back(mk(1,  8,1,1, 11,1,1, 1,10,1, 0,0, 0,0,0,0,0)); // addu released
    tbl.push_back(mk(0,  0,0,0,  0,0,0, 0,0,0,  0,0, 0,0,0,0,1));
    tbl.push_back(mk(1,  0,0,0, 10,1,0, 1,9,1,  0,0, 0,0,2,0,1)); // ori $9, rt from M
    tbl.push_back(mk(1,  9,1,0,  0,1,0, 0,0,0,  0,0, 1,0,0,0,1)); // beq $9 stalls
    tbl.push_back(mk(1,  9,1,0,  0,1,0, 0,0,0,  0,0, 0,2,0,0,1)); // beq fwd from M
    tbl.push_back(mk(1,  9,1,1,  0,0,0, 1,0,2,  0,0, 0,3,0,0,1)); // write $0, rs from W
    tbl.push_back(mk(1,  0,1,0,  0,1,0, 0,0,0,  0,0, 0,0,0,0,1)); // read $0
    tbl.push_back(mk(1,  0,0,0,  0,0,0, 1,5,0,  0,0, 0,0,0,0,1)); // write $5
    tbl.push_back(mk(1,  5,1,0,  0,0,0, 1,5,0,  0,0, 0,1,0,0,1)); // write $5 again
    tbl.push_back(mk(1,  5,1,0,  5,1,0, 0,0,0,  0,0, 0,1,1,0,1)); // younger wins
    tbl.push_back(mk(1,  5,0,0,  5,1,0, 0,0,0,  0,0, 0,0,2,0,1)); // rs unused
    tbl.push_back(mk(1,  0,0,0,  0,0,0, 1,7,2,  0,0, 0,0,0,0,1)); // lw $7
    tbl.push_back(mk(1,  0,0,0,  7,1,0, 0,0,0,  0,0, 1,0,0,0,1)); // rt tuse0: 2 stalls
    tbl.push_back(mk(1,  0,0,0,  7,1,0, 0,0,0,  0,0, 1,0,0,0,1));
    tbl.push_back(mk(1,  0,0,0,  7,1,0, 0,0,0,  0,0, 0,0,3,0,1));
    tbl.push_back(mk(1,  2,1,0,  3,1,0, 0,0,0,  1,0, 0,0,0,0,1)); // mult
    tbl.push_back(mk(1,  0,0,0,  0,0,0, 1,4,1,  0,1, 1,0,0,0,1)); // mflo, start-in-E
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,4,1, 0,1, 1,0,0,1,1)); // busy 5..1
    tbl.push_back(mk(1,  0,0,0,  0,0,0, 1,4,1,  0,1, 0,0,0,0,1)); // released
    tbl.push_back(mk(0,  4,1,0,  0,0,0, 0,0,0,  0,0, 0,0,0,0,1)); // invalid D never stalls
    tbl.push_back(mk(1,  4,1,0,  0,0,0, 0,0,0,  0,0, 0,2,0,0,1));

    hs.push_back(mk(1, 0,0,0, 0,0,0, 1,6,0, 0,0, 0,0,0,0,1)); // writer of $6 behind mult
    hs.push_back(mk(0, 0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,1,1));
    hs.push_back(mk(0, 0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,1,1));

    reset_n = 1'b0;
    drive(mk(1, 3,1,0, 3,1,0, 1,3,2, 0,1, 0,0,0,0,1));
    #2;
    check_out(mk(1, 3,1,0, 3,1,0, 1,3,2, 0,1, 0,0,0,0,1), "reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

    @(negedge clk);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    apply(mk(1, 0,0,0, 0,0,0, 0,0,0, 1,0, 0,0,0,0,1), "h_mult");
    for (int i = 0; i < hs.size(); i++) apply(hs[i], $sformatf("h%0d", i));
    apply(mk(1, 0,0,0, 6,1,0, 1,4,1, 0,1, 1,0,3,1,1), "h_cnt3");
    #1;
    reset_n = 1'b0;
    #1;
    check_out(mk(1, 0,0,0, 6,1,0, 1,4,1, 0,1, 0,0,0,0,1), "h_rst");
    #1;
    reset_n = 1'b1;
    apply(mk(1, 0,0,0, 6,1,0, 1,4,1, 0,1, 0,0,0,0,1), "h_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
